srl16_shift_top: RTL and testbench

Self-checking SRL16 shift-register test block for FPGA bring-up. A 16-bit LFSR feeds eight SRL16E-style addressable shift lanes, each compared every cycle against a flip-flop reference delay line. Any mismatch sets a sticky per-lane error flag on the LEDs. It is the board-level top; the UART pins are unused pass-through.

---
 rtl/srl16_shift_pkg.sv | 21 ++
 rtl/srl16_lane.sv | 68 ++++++
 rtl/srl16_shift_top.sv | 78 +++++++
 tb/tb_srl16_shift_top.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/srl16_shift_pkg.sv
// Shared constants for the SRL16 shift-register bring-up block.
package srl16_shift_pkg;

    localparam int unsigned NUM_LANES = 8;
    localparam int unsigned LFSR_W    = 16;
    localparam int unsigned SRL_DEPTH = 16;
    localparam int unsigned WARMUP    = 32;
    localparam int unsigned WARM_W    = 6;
    localparam int unsigned HB_W      = 24;

    localparam logic [LFSR_W-1:0]    LFSR_SEED = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci LFSR: taps on bits 0,2,3,5
    localparam logic [LFSR_W-1:0]    LFSR_TAPS = 16'h002D;
    localparam logic [SRL_DEPTH-1:0] SRL_INIT  = 16'h0000;

    // Tap address of lane i; delay is lane_addr(i)+1 CE-qualified shifts.
    function automatic int unsigned lane_addr(input int unsigned i);
        return 2 * i + 1;
    endfunction

endpackage

// File: rtl/srl16_lane.sv
// One test lane: SRL16E-style addressable shift register, flop reference
// delay line of identical latency, comparator and sticky error flag.
// Ports: clk, rst_n (async active-low), ce (shift enable), d (shift data),
//        inj (invert reference input), armed (compare enable), err (sticky flag).
module srl16_lane
    import srl16_shift_pkg::*;
#(
    parameter int unsigned ADDR = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic d,
    input  logic inj,
    input  logic armed,
    output logic err
);

    localparam int unsigned REF_W = ADDR + 1;

    logic [SRL_DEPTH-1:0] sr_q, sr_d;
    logic [REF_W-1:0]     ref_q, ref_d;
    logic                 err_q, err_d;
    logic                 srl_out;
    logic                 ref_out;

    // Next-state for SRL, reference chain and sticky flag.
    always_comb begin
        sr_d    = sr_q;
        ref_d   = ref_q;
        srl_out = sr_q[ADDR];
        ref_out = ref_q[REF_W-1];
        if (ce) begin
            sr_d  = {sr_q[SRL_DEPTH-2:0], d};
            ref_d = {ref_q[REF_W-2:0], d ^ inj};
        end
        err_d = err_q | (armed & (srl_out ^ ref_out));
    end

    // SRL contents have no reset in silicon; simulation clears them so runs start clean.
`ifdef SYNTHESIS
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= SRL_INIT;
        end else begin
            sr_q <= sr_d;
        end
    end
`endif

    // Reference chain and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= '0;
            err_q <= 1'b0;
        end else begin
            ref_q <= ref_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/srl16_shift_top.sv
// Board top for SRL16 bring-up: LFSR data source, CE toggle, warm-up counter,
// heartbeat and eight self-checking shift lanes.
// Ports: clk, rst_n (async active-low), rx (unused), tx (held idle high),
//        sw (error-inject switches, only with ERROR_INJECT_EN defined),
//        led[7:0] sticky lane errors, led[8] heartbeat, led[15:9] zero.
// Build option: define ERROR_INJECT_EN to let sw[7:0] corrupt lane references.
module srl16_shift_top
    import srl16_shift_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic        tx,
    input  logic [15:0] sw,
    output logic [15:0] led
);

    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic                 ce_tgl_q, ce_tgl_d;
    logic [WARM_W-1:0]    warm_q, warm_d;
    logic [HB_W-1:0]      hb_q, hb_d;
    logic                 armed_c;
    logic [NUM_LANES-1:0] inj_c;
    logic [NUM_LANES-1:0] err_c;
    logic                 unused_pins;

    // Shared datapath next-state.
    always_comb begin
        lfsr_d   = {^(lfsr_q & LFSR_TAPS), lfsr_q[LFSR_W-1:1]};
        ce_tgl_d = ~ce_tgl_q;
        armed_c  = (warm_q == WARM_W'(WARMUP));
        warm_d   = armed_c ? warm_q : warm_q + WARM_W'(1);
        hb_d     = hb_q + HB_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q   <= LFSR_SEED;
            ce_tgl_q <= 1'b0;
            warm_q   <= '0;
            hb_q     <= '0;
        end else begin
            lfsr_q   <= lfsr_d;
            ce_tgl_q <= ce_tgl_d;
            warm_q   <= warm_d;
            hb_q     <= hb_d;
        end
    end

`ifdef ERROR_INJECT_EN
    assign inj_c = sw[NUM_LANES-1:0];
`else
    assign inj_c = '0;
`endif

    // Even lanes shift every cycle, odd lanes on alternate cycles.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic lane_ce;
        assign lane_ce = (gi % 2 == 0) ? 1'b1 : ce_tgl_q;

        srl16_lane #(
            .ADDR (lane_addr(gi))
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .ce    (lane_ce),
            .d     (lfsr_q[0]),
            .inj   (inj_c[gi]),
            .armed (armed_c),
            .err   (err_c[gi])
        );
    end

    assign unused_pins = ^{rx, sw};
    assign tx          = 1'b1;
    assign led         = {7'b0, hb_q[HB_W-1], err_c};

endmodule

// File: tb/tb_srl16_shift_top.sv
module tb_srl16_shift_top;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic        tx;
    logic [15:0] sw;
    logic [15:0] sw_tb;
    logic [15:0] led;
    logic [7:0]  inj_tb;

    int vec_cnt;
    int err_cnt;

    // Independent reference model state
    logic [15:0] lfsr_m;
    logic        ce_m;
    logic [15:0] sr3_m;
    int          warm_m;
    int          hb_m;

    srl16_shift_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .tx    (tx),
        .sw    (sw),
        .led   (led)
    );

`ifdef ERROR_INJECT_EN
    assign sw = sw_tb | {8'h00, inj_tb};
`else
    assign sw = sw_tb;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        lfsr_m = 16'hACE1;
        ce_m   = 1'b0;
        sr3_m  = 16'h0000;
        warm_m = 0;
        hb_m   = 0;
    endtask

    // One clock; model advances on the edge, DUT is sampled at the next falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (ce_m) sr3_m = {sr3_m[14:0], lfsr_m[0]};
            lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
            ce_m   = ~ce_m;
            if (warm_m != 32) warm_m++;
            hb_m++;
        end
        @(negedge clk);
    endtask

    task automatic check_model();
        check("lfsr",  32'(dut.lfsr_q), 32'(lfsr_m));
        check("armed", 32'(dut.armed_c), (warm_m == 32) ? 32'd1 : 32'd0);
        check("hb",    32'(dut.hb_q), 32'(hb_m));
        check("led_hb", 32'(led[8]), 32'(hb_m[23]));
        check("led_hi", 32'(led[15:9]), 32'd0);
        check("tx",    32'(tx), 32'd1);
    endtask

    initial begin
        int n;
        vec_cnt = 0;
        err_cnt = 0;
        inj_tb  = 8'h00;
        sw_tb   = 16'h0000;
        rx      = 1'b1;
        rst_n   = 1'b0;
        model_reset();
`ifndef ERROR_INJECT_EN
        force dut.inj_c = inj_tb;
`endif

        // Reset held for 3 cycles
        repeat (3) tick();
        check("rst_led",  32'(led), 32'h0000);
        check("rst_tx",   32'(tx), 32'd1);
        check("rst_lfsr", 32'(dut.lfsr_q), 32'hACE1);

        // First LFSR step from ACE1: feedback 0, value 5670
        rst_n = 1'b1;
        tick();
        check("lfsr_step1", 32'(dut.lfsr_q), 32'h5670);

        // Free run: no errors, lane 3 tap matches delayed data
        for (int i = 0; i < 5000; i++) begin
            tick();
            check("run_err", 32'(led[7:0]), 32'h00);
            check("lane3_q", 32'(dut.g_lane[3].u_lane.srl_out), 32'(sr3_m[7]));
            check_model();
        end

`ifndef ERROR_INJECT_EN
        // Switches have no effect in the default build
        inj_tb = 8'h00;
        release dut.inj_c;
        sw_tb = 16'hFFFF;
        for (int i = 0; i < 200; i++) begin
            tick();
            check("sw_ignored", 32'(led[7:0]), 32'h00);
        end
        sw_tb = 16'h0000;
        force dut.inj_c = inj_tb;
`endif

        // Lane 0 injection: flag appears on the third edge, not earlier
        inj_tb = 8'h01;
        tick();
        tick();
        check("inj0_edge2", 32'(led[7:0]), 32'h00);
        tick();
        check("inj0_edge3", 32'(led[7:0]), 32'h01);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("inj0_hold", 32'(led[7:0]), 32'h01);
        end

        // Lane 7 injection: within 33 cycles, sticky after switch clears
        inj_tb = 8'h80;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            n = i;
            if (led[7]) break;
        end
        check("inj7_latency", (n <= 33) ? 32'd1 : 32'd0, 32'd1);
        check("inj7_led", 32'(led[7:0]), 32'h81);
        inj_tb = 8'h00;
        repeat (40) tick();
        check("inj7_sticky", 32'(led[7:0]), 32'h81);

        // Mid-run reset clears immediately; warm-up masks the first 32 cycles
        inj_tb = 8'hFF;
        rst_n  = 1'b0;
        #1;
        check("midrst_led",  32'(led[7:0]), 32'h00);
        check("midrst_lfsr", 32'(dut.lfsr_q), 32'hACE1);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            check("warmup_mask", 32'(led[7:0]), 32'h00);
            check_model();
        end
        tick();
        check("armed_all", 32'(led[7:0]), 32'hFF);

        // Clean reset at the end
        inj_tb = 8'h00;
        rst_n  = 1'b0;
        #1;
        check("final_rst", 32'(led), 32'h0000);
        tick();
        rst_n = 1'b1;
        model_reset();
        repeat (10) tick();
        check("final_run", 32'(led[7:0]), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
